// File: rtl/cg_alu_pkg.sv
// rtl/cg_alu_pkg.sv - shared FSM encoding and pipeline constants for the dot-product unit
package cg_alu_pkg;

    typedef logic [1:0] dot_state_t;

    localparam dot_state_t ST_IDLE  = 2'd0;
    localparam dot_state_t ST_RUN   = 2'd1;
    localparam dot_state_t ST_DRAIN = 2'd2;
    localparam dot_state_t ST_DONE  = 2'd3;

    // multiply -> adder tree -> accumulate
    localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/vxv_adder_tree.sv
// rtl/vxv_adder_tree.sv - combinational balanced adder tree over no_of_units packed terms
module vxv_adder_tree #(
    parameter int no_of_units = 8,
    parameter int acc_width   = 64
) (
    input  logic [no_of_units*acc_width-1:0] terms_i,
    output logic [acc_width-1:0]             sum_o
);

    // Leaves are padded to the next power of two with zeros so any lane count works.
    localparam int LEAVES = 1 << $clog2(no_of_units);

    logic [acc_width-1:0] lvl [LEAVES];

    // Pairwise reduction, level by level; each level halves the live width in place.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            if (i < no_of_units) begin
                lvl[i] = terms_i[i*acc_width +: acc_width];
            end else begin
                lvl[i] = '0;
            end
        end
        for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                lvl[i] = lvl[2*i] + lvl[2*i+1];
            end
        end
        sum_o = lvl[0];
    end

endmodule

// File: rtl/vxv_dot_unit.sv
// rtl/vxv_dot_unit.sv - streaming signed vector dot product with 3-stage pipeline
module vxv_dot_unit
    import cg_alu_pkg::*;
#(
    parameter int no_of_units   = 8,
    parameter int element_width = 32,
    parameter int acc_width     = 64,
    parameter int len_width     = 20
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 mode,
    input  logic [len_width-1:0]                 len_beats,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [no_of_units*element_width-1:0] a_in,
    input  logic [no_of_units*element_width-1:0] b_in,
    output logic                                 busy,
    output logic                                 finish,
    output logic [acc_width-1:0]                 result
);

    dot_state_t                        state_q, state_d;
    logic                              mode_q;
    logic [len_width-1:0]              len_q;
    logic [len_width-1:0]              cnt_q;
    logic                              s1_valid_q;
    logic                              s2_valid_q;
    logic [no_of_units*acc_width-1:0]  prod_d, prod_q;
    logic [acc_width-1:0]              sum_d, sum_q;
    logic [acc_width-1:0]              acc_q;
    logic [acc_width-1:0]              result_q;
    logic                              start_ok;
    logic                              beat_ok;
    logic                              last_beat;

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign beat_ok   = in_valid && in_ready;
    assign last_beat = beat_ok && (cnt_q == len_q - len_width'(1));

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q != ST_IDLE);
    assign finish   = (state_q == ST_DONE);
    assign result   = result_q;

    // Next-state: DRAIN waits until neither product nor sum stage holds a live beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len_beats == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane products; in mode 1 the a lane is squared and b is ignored.
    always_comb begin
        logic signed [element_width-1:0]   a_l;
        logic signed [element_width-1:0]   b_l;
        logic signed [2*element_width-1:0] p;
        a_l    = '0;
        b_l    = '0;
        p      = '0;
        prod_d = '0;
        for (int i = 0; i < no_of_units; i++) begin
            a_l = a_in[i*element_width +: element_width];
            b_l = mode_q ? a_l : b_in[i*element_width +: element_width];
            p   = (2*element_width)'(a_l) * (2*element_width)'(b_l);
            prod_d[i*acc_width +: acc_width] = acc_width'(p);
        end
    end

    vxv_adder_tree #(
        .no_of_units (no_of_units),
        .acc_width   (acc_width)
    ) u_tree (
        .terms_i (prod_q),
        .sum_o   (sum_d)
    );

    // Control registers: operation parameters latched on an accepted start, beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                mode_q <= mode;
                len_q  <= len_beats;
                cnt_q  <= '0;
            end else if (beat_ok) begin
                cnt_q <= cnt_q + len_width'(1);
            end
        end
    end

    // Datapath pipeline; valid bits travel with beats so input gaps become bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= beat_ok;
            if (beat_ok) begin
                prod_q <= prod_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q <= sum_d;
            end
            if (start_ok) begin
                acc_q <= '0;
            end else if (s2_valid_q) begin
                acc_q <= acc_q + sum_q;
            end
        end
    end

    // Result register loads as the FSM enters DONE; an empty run reports zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            result_q <= (state_q == ST_IDLE) ? '0 : acc_q;
        end
    end

endmodule
